mult_div_unit: RTL and testbench

// - Sequential signed multiply/divide unit with HI/LO registers; sits directly downstream of the control unit.
// - The control unit drives mult_div in its MULT_LOAD/DIV_LOAD states, waits in MULT_CALC/DIV_CALC until done,
//   and consumes div0 for the DIVZERO exception. MFHI/MFLO read hi_out/lo_out through the mem_to_reg mux.
// - Multiply uses radix-2 Booth over 32 iterations. Divide uses signed restoring division over 32 iterations.

---
 rtl/mult_div_unit.sv | 202 ++++++++++++++++++++
 tb/tb_mult_div_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Sequential signed multiply/divide unit with HI/LO result registers (radix-2 Booth MULT, restoring DIV).
// Optional build macro MDU_FAST_ZERO_EN: a MULT with a zero operand completes on the accepting edge.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       mult_div,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int              CNT_W     = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MULT,
        S_DIV
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH:0]   acc_q, acc_d;       // Booth A (sign-extended) / division partial remainder
    logic [WIDTH-1:0] qreg_q, qreg_d;     // Booth Q (multiplier) / dividend magnitude -> quotient
    logic             q_m1_q, q_m1_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;     // multiplicand / divisor magnitude
    logic             neg_quot_q, neg_quot_d;
    logic             neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;
    logic             div0_q, div0_d;

    logic             fast_zero;

`ifdef MDU_FAST_ZERO_EN
    assign fast_zero = (a_in == '0) || (b_in == '0);
`else
    assign fast_zero = 1'b0;
`endif

    // Booth step: add/subtract multiplicand per {Q0,Q-1}, then arithmetic right shift of {A,Q,Q-1}.
    // A carries one extra sign bit so that subtracting -2^31 cannot overflow.
    logic [WIDTH:0]   m_ext;
    logic [WIDTH:0]   booth_sum;
    logic [WIDTH:0]   booth_acc;
    logic [WIDTH-1:0] booth_q;

    always_comb begin
        m_ext = {opnd_q[WIDTH-1], opnd_q};
        case ({qreg_q[0], q_m1_q})
            2'b01:   booth_sum = acc_q + m_ext;
            2'b10:   booth_sum = acc_q - m_ext;
            default: booth_sum = acc_q;
        endcase
        booth_acc = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
        booth_q   = {booth_sum[0], qreg_q[WIDTH-1:1]};
    end

    // Restoring step on magnitudes: the remainder stays below the divisor, so it always fits WIDTH bits.
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   div_trial;
    logic [WIDTH-1:0] div_acc;
    logic [WIDTH-1:0] div_q;
    logic [WIDTH-1:0] quot_final;
    logic [WIDTH-1:0] rem_final;

    always_comb begin
        rem_shift = {acc_q[WIDTH-1:0], qreg_q[WIDTH-1]};
        div_trial = rem_shift - {1'b0, opnd_q};
        if (!div_trial[WIDTH]) begin
            div_acc = div_trial[WIDTH-1:0];
            div_q   = {qreg_q[WIDTH-2:0], 1'b1};
        end else begin
            div_acc = rem_shift[WIDTH-1:0];
            div_q   = {qreg_q[WIDTH-2:0], 1'b0};
        end
        quot_final = neg_quot_q ? -div_q   : div_q;
        rem_final  = neg_rem_q  ? -div_acc : div_acc;
    end

    always_comb begin
        // NOTE: every next-state signal gets a default first, so no path through the case can infer a latch.
        state_d    = state_q;
        count_d    = count_q;
        acc_d      = acc_q;
        qreg_d     = qreg_q;
        q_m1_d     = q_m1_q;
        opnd_d     = opnd_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        div0_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (mult_div == 2'b01) begin
                    if (fast_zero) begin
                        hi_d   = '0;
                        lo_d   = '0;
                        done_d = 1'b1;
                    end else begin
                        state_d = S_MULT;
                        count_d = '0;
                        acc_d   = '0;
                        qreg_d  = a_in;
                        q_m1_d  = 1'b0;
                        opnd_d  = b_in;
                    end
                end else if (mult_div == 2'b10) begin
                    if (b_in == '0) begin
                        done_d = 1'b1;
                        div0_d = 1'b1;
                    end else begin
                        state_d    = S_DIV;
                        count_d    = '0;
                        acc_d      = '0;
                        qreg_d     = a_in[WIDTH-1] ? -a_in : a_in;
                        opnd_d     = b_in[WIDTH-1] ? -b_in : b_in;
                        neg_quot_d = a_in[WIDTH-1] ^ b_in[WIDTH-1];
                        neg_rem_d  = a_in[WIDTH-1];
                    end
                end
            end

            S_MULT: begin
                acc_d   = booth_acc;
                qreg_d  = booth_q;
                q_m1_d  = qreg_q[0];
                count_d = count_q + 1'b1;
                if (count_q == LAST_ITER) begin
                    hi_d    = booth_acc[WIDTH-1:0];
                    lo_d    = booth_q;
                    done_d  = 1'b1;
                    count_d = '0;
                    state_d = S_IDLE;
                end
            end

            S_DIV: begin
                acc_d   = {1'b0, div_acc};
                qreg_d  = div_q;
                count_d = count_q + 1'b1;
                if (count_q == LAST_ITER) begin
                    hi_d    = rem_final;
                    lo_d    = quot_final;
                    done_d  = 1'b1;
                    count_d = '0;
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (!reset) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            acc_q      <= '0;
            qreg_q     <= '0;
            q_m1_q     <= 1'b0;
            opnd_q     <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            div0_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            acc_q      <= acc_d;
            qreg_q     <= qreg_d;
            q_m1_q     <= q_m1_d;
            opnd_q     <= opnd_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
            div0_q     <= div0_d;
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = done_q;
    assign div0   = div0_q;
    assign hi_out = hi_q;
    assign lo_out = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus random MULT/DIV against a
// plain-arithmetic reference model (64-bit signed product, truncating signed divide/modulo).
module tb_mult_div_unit;

    logic        clock;
    logic        reset;
    logic [1:0]  mult_div;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        busy;
    logic        done;
    logic        div0;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clock   (clock),
        .reset   (reset),
        .mult_div(mult_div),
        .a_in    (a_in),
        .b_in    (b_in),
        .busy    (busy),
        .done    (done),
        .div0    (div0),
        .hi_out  (hi_out),
        .lo_out  (lo_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void ref_mult(input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] hi, output logic [31:0] lo);
        longint p;
        p  = longint'($signed(a)) * longint'($signed(b));
        hi = p[63:32];
        lo = p[31:0];
    endfunction

    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] hi, output logic [31:0] lo);
        longint sa, sb, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = sa / sb;
        r  = sa % sb;
        hi = r[31:0];
        lo = q[31:0];
    endfunction

    // Edges counted from the accepting edge (inclusive) until done is visible.
    function automatic int mult_edges(input logic [31:0] a, input logic [31:0] b);
`ifdef MDU_FAST_ZERO_EN
        if (a == '0 || b == '0) return 1;
`endif
        return 33;
    endfunction

    // Issue one command and follow it to done. b2b: drive the command in the current (done) cycle.
    // poke_at: edge index at which a spurious DIV command is driven for one cycle (0 = none).
    task automatic run_op(input string tag, input logic [1:0] cmd, input logic [31:0] a,
                          input logic [31:0] b, input int exp_edges, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input logic exp_div0, input bit b2b,
                          input int poke_at);
        int edges       = 0;
        int busy_cycles = 0;
        bit seen        = 0;
        if (!b2b) begin
            @(negedge clock);
            check({tag, "_pulse_clear"}, {62'd0, done, div0}, 64'd0);
        end
        mult_div = cmd;
        a_in     = a;
        b_in     = b;
        while (!seen && edges < 100) begin
            @(posedge clock);
            edges++;
            @(negedge clock);
            if (edges == 1 || edges == poke_at + 1) begin
                mult_div = 2'b00;
                a_in     = $urandom;
                b_in     = $urandom;
            end
            if (edges == poke_at) mult_div = 2'b10;
            if (busy) busy_cycles++;
            if (done) seen = 1;
        end
        check({tag, "_latency"}, 64'(edges), 64'(exp_edges));
        check({tag, "_busy_cycles"}, 64'(busy_cycles), 64'(exp_edges - 1));
        check({tag, "_hi"}, {32'd0, hi_out}, {32'd0, exp_hi});
        check({tag, "_lo"}, {32'd0, lo_out}, {32'd0, exp_lo});
        check({tag, "_div0"}, {63'd0, div0}, {63'd0, exp_div0});
        check({tag, "_busy_end"}, {63'd0, busy}, 64'd0);
        m_hi = exp_hi;
        m_lo = exp_lo;
    endtask

    task automatic do_mult(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input bit b2b, input int poke_at);
        logic [31:0] eh, el;
        ref_mult(a, b, eh, el);
        run_op(tag, 2'b01, a, b, mult_edges(a, b), eh, el, 1'b0, b2b, poke_at);
    endtask

    task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input bit b2b);
        logic [31:0] eh, el;
        if (b == '0) begin
            run_op(tag, 2'b10, a, b, 1, m_hi, m_lo, 1'b1, b2b, 0);
        end else begin
            ref_div(a, b, eh, el);
            run_op(tag, 2'b10, a, b, 33, eh, el, 1'b0, b2b, 0);
        end
    endtask

    initial begin
        int dones;
        logic [31:0] ra, rb;
        reset    = 1'b0;
        mult_div = 2'b00;
        a_in     = '0;
        b_in     = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("reset_state", {busy, done, div0, hi_out, lo_out}, 67'd0);
        reset = 1'b1;

        run_op("mul_7_m3", 2'b01, 32'd7, 32'hFFFF_FFFD, 33, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 0, 0);
        run_op("mul_min_min", 2'b01, 32'h8000_0000, 32'h8000_0000, 33, 32'h4000_0000, 32'h0, 1'b0, 0, 0);
        run_op("div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 0, 0);
        run_op("div_min_m1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0, 32'h8000_0000, 1'b0, 0, 0);

        run_op("mul_preload", 2'b01, 32'h0011_0000, 32'h0001_0000, 33, 32'h11, 32'h0, 1'b0, 0, 0);
        run_op("div_5_0", 2'b10, 32'd5, 32'd0, 1, 32'h11, 32'h0, 1'b1, 0, 0);

        // Command 11 must be treated as no command.
        @(negedge clock);
        mult_div = 2'b11;
        a_in     = 32'd9;
        b_in     = 32'd0;
        dones    = 0;
        repeat (4) begin
            @(negedge clock);
            if (done || busy) dones++;
        end
        mult_div = 2'b00;
        check("cmd11_idle", 64'(dones), 64'd0);
        check("cmd11_hilo", {hi_out, lo_out}, {m_hi, m_lo});

        // Reset during iteration 10 aborts the MULT with no done pulse.
        @(negedge clock);
        mult_div = 2'b01;
        a_in     = 32'd3;
        b_in     = 32'd4;
        @(negedge clock);
        mult_div = 2'b00;
        repeat (9) @(negedge clock);
        check("abort_busy_before", {63'd0, busy}, 64'd1);
        reset = 1'b0;
        @(negedge clock);
        check("abort_state", {busy, done, div0, hi_out, lo_out}, 67'd0);
        reset = 1'b1;
        dones = 0;
        repeat (40) begin
            @(negedge clock);
            if (done || busy) dones++;
        end
        check("abort_no_done", 64'(dones), 64'd0);
        m_hi = '0;
        m_lo = '0;

        run_op("mul_3_4_fresh", 2'b01, 32'd3, 32'd4, 33, 32'h0, 32'd12, 1'b0, 0, 0);
        do_mult("mul_0_5", 32'd0, 32'd5, 0, 0);
        do_mult("mul_busy_poke", 32'h1234_5678, 32'hFEDC_BA98, 0, 6);
        do_div("div_pre_b2b", 32'd1000, 32'hFFFF_FFF9, 0);
        do_mult("mul_b2b", 32'hFFFF_FF00, 32'd77, 1, 0);
        do_div("div_b2b", 32'h7FFF_FFFF, 32'd3, 1);

        for (int i = 0; i < 10; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 5 == 4) rb = rb & 32'h0000_000F;
            if (i % 2 == 0) begin
                do_mult($sformatf("rnd_mul%0d", i), ra, rb, 0, 0);
            end else begin
                if (rb == '0) rb = 32'd1;
                do_div($sformatf("rnd_div%0d", i), ra, rb, 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
